// File: rtl/exu_alu_rs.sv
// ALU reservation station: 4-entry age-ordered queue with tag wakeup, dispatch bypass
// and oldest-ready-first issue. Entries compact toward index 0 as they issue.
module exu_alu_rs (
    input  logic         clk,
    input  logic         rst_clk,
    input  logic         rtu_global_flush,
    input  logic         idu_rs_vld,
    input  logic [156:0] idu_rs_inst,
    input  logic         idu_rs_src1_vld,
    input  logic         idu_rs_src1_rdy,
    input  logic [5:0]   idu_rs_src1_preg,
    input  logic [63:0]  idu_rs_src1_value,
    input  logic         idu_rs_src2_vld,
    input  logic         idu_rs_src2_rdy,
    input  logic [5:0]   idu_rs_src2_preg,
    input  logic [63:0]  idu_rs_src2_value,
    input  logic         wb_vld,
    input  logic [5:0]   wb_preg,
    input  logic [63:0]  wb_data,
    output logic         rs_idu_full,
    output logic         rs_alu_vld,
    output logic [156:0] rs_alu_inst,
    output logic         rs_alu_src1_vld,
    output logic [63:0]  rs_alu_src1_value,
    output logic         rs_alu_src2_vld,
    output logic [63:0]  rs_alu_src2_value
);

    typedef struct packed {
        logic        vld;
        logic        rdy;
        logic [5:0]  preg;
        logic [63:0] value;
    } rs_src_t;

    typedef struct packed {
        logic         vld;
        logic [156:0] inst;
        rs_src_t      src1;
        rs_src_t      src2;
    } rs_entry_t;

    // Capture a writeback into a source still waiting on that tag.
    function automatic rs_src_t wake_src(input rs_src_t s, input logic wb_v,
                                         input logic [5:0] wb_p, input logic [63:0] wb_d);
        rs_src_t r;
        r = s;
        if (wb_v && s.vld && !s.rdy && (s.preg == wb_p)) begin
            r.rdy   = 1'b1;
            r.value = wb_d;
        end
        return r;
    endfunction

    rs_entry_t  ent_q [4];
    rs_entry_t  ent_d [4];
    rs_entry_t  woke  [4];
    rs_entry_t  new_ent;
    logic [2:0] count;
    logic [3:0] ent_rdy;
    logic [1:0] sel;
    logic       found;
    logic       issue;
    logic       disp_acc;
    logic [1:0] wr_idx;

    always_comb begin
        count   = '0;
        ent_rdy = '0;
        sel     = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            count      = count + 3'(ent_q[i].vld);
            ent_rdy[i] = ent_q[i].vld
                       & (~ent_q[i].src1.vld | ent_q[i].src1.rdy)
                       & (~ent_q[i].src2.vld | ent_q[i].src2.rdy);
        end
        for (int unsigned i = 0; i < 4; i++) begin
            if (ent_rdy[i] && !found) begin
                sel   = 2'(i);
                found = 1'b1;
            end
        end
    end

    assign rs_idu_full = (count == 3'd4);
    assign issue       = (|ent_rdy) & ~rtu_global_flush;
    assign disp_acc    = idu_rs_vld & ~rs_idu_full & ~rtu_global_flush;
    // Only reached with count <= 3, so two bits suffice for the slot index.
    assign wr_idx      = count[1:0] - {1'b0, issue};

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            woke[i]      = ent_q[i];
            woke[i].src1 = wake_src(ent_q[i].src1, wb_vld & ent_q[i].vld, wb_preg, wb_data);
            woke[i].src2 = wake_src(ent_q[i].src2, wb_vld & ent_q[i].vld, wb_preg, wb_data);
        end

        new_ent.vld  = 1'b1;
        new_ent.inst = idu_rs_inst;
        new_ent.src1 = wake_src(rs_src_t'({idu_rs_src1_vld, idu_rs_src1_rdy,
                                           idu_rs_src1_preg, idu_rs_src1_value}),
                                wb_vld, wb_preg, wb_data);
        new_ent.src2 = wake_src(rs_src_t'({idu_rs_src2_vld, idu_rs_src2_rdy,
                                           idu_rs_src2_preg, idu_rs_src2_value}),
                                wb_vld, wb_preg, wb_data);

        // Wakeup is applied before compaction so shifted entries still see this cycle's writeback.
        for (int unsigned i = 0; i < 3; i++) begin
            ent_d[i] = (issue && (2'(i) >= sel)) ? woke[i+1] : woke[i];
        end
        ent_d[3] = issue ? '0 : woke[3];

        if (disp_acc) begin
            ent_d[wr_idx] = new_ent;
        end

        if (rtu_global_flush) begin
            for (int unsigned i = 0; i < 4; i++) begin
                ent_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_clk) begin
        if (!rst_clk) begin
            for (int unsigned i = 0; i < 4; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

    assign rs_alu_vld        = issue;
    assign rs_alu_inst       = issue ? ent_q[sel].inst : '0;
    assign rs_alu_src1_vld   = issue & ent_q[sel].src1.vld;
    assign rs_alu_src1_value = issue ? ent_q[sel].src1.value : '0;
    assign rs_alu_src2_vld   = issue & ent_q[sel].src2.vld;
    assign rs_alu_src2_value = issue ? ent_q[sel].src2.value : '0;

endmodule
